updown_seq_ctrl: RTL and testbench

Sequencing controller for the 3-bit up/down counter datapath. It accepts a command (go-to-target or bounded ping-pong sweep) and drives the counter's direction (`ud`) and step-enable (`cnt_en`) one step at a time. It tracks a shadow position and checks it against the counter's fed-back value when the command finishes. It sits between the top-level command source and the counter.

---
 rtl/updown_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_updown_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: command sequencer for a 3-bit up/down counter.
// Runs GOTO (move to target) or SWEEP (ping-pong between lo/hi for a number
// of legs), issuing one registered step per cycle. It keeps a shadow position
// and checks it against the counter's fed-back value on completion.
module updown_seq_ctrl #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_target,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [3:0]       i_turns,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_q_in,
    output logic             o_ud,
    output logic             o_cnt_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_err_code
);

    localparam logic [1:0] MODE_GOTO  = 2'b00;
    localparam logic [1:0] MODE_SWEEP = 2'b01;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_BAD_ARGS = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_ABORTED  = 2'b11;

    localparam logic [WIDTH-1:0] POS_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SETTLE
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [1:0]       r_mode,    w_mode_nxt;
    logic [WIDTH-1:0] r_target,  w_target_nxt;
    logic [WIDTH-1:0] r_lo,      w_lo_nxt;
    logic [WIDTH-1:0] r_hi,      w_hi_nxt;
    logic [3:0]       r_turns,   w_turns_nxt;
    logic [WIDTH-1:0] r_pos,     w_pos_nxt;
    logic [3:0]       r_legs,    w_legs_nxt;
    logic             r_dir,     w_dir_nxt;
    logic             r_aborted, w_aborted_nxt;
    logic             r_ud,      w_ud_nxt;
    logic             r_cnt_en,  w_cnt_en_nxt;
    logic             r_done,    w_done_nxt;
    logic [1:0]       r_err,     w_err_nxt;

    logic             w_bad_args;
    logic             w_at_bound;
    logic [3:0]       w_legs_dec;

    assign w_bad_args = r_mode[1] ||
                        ((r_mode == MODE_SWEEP) &&
                         ((r_lo >= r_hi) || (i_q_in < r_lo) || (i_q_in > r_hi)));
    assign w_at_bound = r_dir ? (r_pos == r_hi) : (r_pos == r_lo);
    assign w_legs_dec = r_legs - 4'd1;

    // State and output registers; reset returns everything to idle immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= MODE_GOTO;
            r_target  <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_turns   <= '0;
            r_pos     <= '0;
            r_legs    <= '0;
            r_dir     <= 1'b1;
            r_aborted <= 1'b0;
            r_ud      <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= ERR_OK;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_target  <= w_target_nxt;
            r_lo      <= w_lo_nxt;
            r_hi      <= w_hi_nxt;
            r_turns   <= w_turns_nxt;
            r_pos     <= w_pos_nxt;
            r_legs    <= w_legs_nxt;
            r_dir     <= w_dir_nxt;
            r_aborted <= w_aborted_nxt;
            r_ud      <= w_ud_nxt;
            r_cnt_en  <= w_cnt_en_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state logic: command acceptance, arg check, stepping and completion.
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_target_nxt  = r_target;
        w_lo_nxt      = r_lo;
        w_hi_nxt      = r_hi;
        w_turns_nxt   = r_turns;
        w_pos_nxt     = r_pos;
        w_legs_nxt    = r_legs;
        w_dir_nxt     = r_dir;
        w_aborted_nxt = r_aborted;
        w_ud_nxt      = r_ud;
        w_cnt_en_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = S_LOAD;
                    w_mode_nxt    = i_mode;
                    w_target_nxt  = i_target;
                    w_lo_nxt      = i_lo;
                    w_hi_nxt      = i_hi;
                    w_turns_nxt   = i_turns;
                    w_aborted_nxt = 1'b0;
                    w_err_nxt     = ERR_OK;
                end
            end

            S_LOAD: begin
                w_pos_nxt = i_q_in;
                if (w_bad_args) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = ERR_BAD_ARGS;
                end else begin
                    w_state_nxt = S_RUN;
                    if (r_mode == MODE_SWEEP) begin
                        w_dir_nxt  = (i_q_in != r_hi);
                        w_legs_nxt = r_turns;
                    end
                end
            end

            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt   = S_SETTLE;
                    w_aborted_nxt = 1'b1;
                end else if (r_mode == MODE_GOTO) begin
                    if (r_pos == r_target) begin
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_cnt_en_nxt = 1'b1;
                        w_ud_nxt     = (r_target > r_pos);
                        w_pos_nxt    = (r_target > r_pos) ? r_pos + POS_ONE : r_pos - POS_ONE;
                    end
                end else begin
                    if (r_legs == 4'd0) begin
                        w_state_nxt = S_SETTLE;
                    end else if (w_at_bound) begin
                        // A bound ends one leg; the reversal step goes out on the same edge.
                        w_legs_nxt = w_legs_dec;
                        if (w_legs_dec == 4'd0) begin
                            w_state_nxt = S_SETTLE;
                        end else begin
                            w_dir_nxt    = !r_dir;
                            w_cnt_en_nxt = 1'b1;
                            w_ud_nxt     = !r_dir;
                            w_pos_nxt    = r_dir ? r_pos - POS_ONE : r_pos + POS_ONE;
                        end
                    end else begin
                        w_cnt_en_nxt = 1'b1;
                        w_ud_nxt     = r_dir;
                        w_pos_nxt    = r_dir ? r_pos + POS_ONE : r_pos - POS_ONE;
                    end
                end
            end

            S_SETTLE: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
                if (r_aborted) begin
                    w_err_nxt = ERR_ABORTED;
                end else if (i_q_in != r_pos) begin
                    w_err_nxt = ERR_MISMATCH;
                end else begin
                    w_err_nxt = ERR_OK;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_ud       = r_ud;
    assign o_cnt_en   = r_cnt_en;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_err_code = r_err;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl with a behavioural counter in the loop.
module tb_updown_seq_ctrl;

    localparam int unsigned WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] target, lo, hi;
    logic [3:0]       turns;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             ud, cnt_en, busy, done;
    logic [1:0]       err;

    logic             preload_en = 1'b0;
    logic [WIDTH-1:0] preload_val = '0;
    logic             drop_en = 1'b0;
    int unsigned      seen;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations collected by run_cmd
    int               r_done_edge, r_steps, r_first, r_last;
    logic [15:0]      r_ud_bits;
    logic [1:0]       r_err, r_err_start;
    logic [WIDTH-1:0] r_q;
    logic             r_busy1, r_busy_after;

    always #5 clk = ~clk;

    updown_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_mode     (mode),
        .i_target   (target),
        .i_lo       (lo),
        .i_hi       (hi),
        .i_turns    (turns),
        .i_abort    (abort),
        .i_q_in     (q),
        .o_ud       (ud),
        .o_cnt_en   (cnt_en),
        .o_busy     (busy),
        .o_done     (done),
        .o_err_code (err)
    );

    // Counter model: applies a step one edge after it is issued; can drop the first step.
    always @(posedge clk) begin
        if (preload_en) begin
            q    <= preload_val;
            seen <= 0;
        end else if (cnt_en) begin
            seen <= seen + 1;
            if (!(drop_en && seen == 0))
                q <= ud ? q + 3'd1 : q - 3'd1;
        end
    end

    task automatic preload_q(input logic [WIDTH-1:0] v);
        preload_en  = 1'b1;
        preload_val = v;
        @(posedge clk); #1;
        preload_en  = 1'b0;
    endtask

    // Issues a command (start sampled on edge 0) and records steps/done per edge.
    task automatic run_cmd(input logic [1:0] m, input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] l,
                           input logic [WIDTH-1:0] h, input logic [3:0] tr,
                           input int abort_edge, input int poke_edge);
        mode = m; target = t; lo = l; hi = h; turns = tr; start = 1'b1;
        r_done_edge = -1; r_steps = 0; r_first = -1; r_last = -1;
        r_ud_bits = '0; r_err = 2'bxx; r_q = 'x; r_busy1 = 1'b0;
        @(posedge clk); #1;
        r_err_start = err;
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            abort = (e == abort_edge);
            if (e == poke_edge) begin
                start = 1'b1; mode = 2'b01; target = ~t; lo = 3'd0; hi = 3'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (e == 1) r_busy1 = busy;
            if (cnt_en) begin
                if (r_first < 0) r_first = e;
                r_last = e;
                if (r_steps < 16) r_ud_bits[r_steps] = ud;
                r_steps++;
            end
            if (done) begin
                r_done_edge = e;
                r_err = err;
                r_q = q;
                break;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        r_busy_after = busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
        target = '0; lo = '0; hi = '0; turns = '0;
        #2;
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b expected 0", cnt_en); end
        n_checks++; if (ud !== 1'b0) begin n_fail++; $display("FAIL reset_ud: got %b expected 0", ud); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", err); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_goto_up;
        preload_q(3'd1);
        run_cmd(2'b00, 3'd5, 3'd0, 3'd0, 4'd0, 0, 0);
        n_checks++; if (r_steps !== 4) begin n_fail++; $display("FAIL goto_steps: got %0d expected 4", r_steps); end
        n_checks++; if (r_first !== 2 || r_last !== 5) begin n_fail++; $display("FAIL goto_step_edges: got %0d..%0d expected 2..5", r_first, r_last); end
        n_checks++; if (r_ud_bits[3:0] !== 4'b1111) begin n_fail++; $display("FAIL goto_ud: got %b expected 1111", r_ud_bits[3:0]); end
        n_checks++; if (r_done_edge !== 7) begin n_fail++; $display("FAIL goto_done_edge: got %0d expected 7", r_done_edge); end
        n_checks++; if (r_err !== 2'b00) begin n_fail++; $display("FAIL goto_err: got %b expected 00", r_err); end
        n_checks++; if (r_q !== 3'd5) begin n_fail++; $display("FAIL goto_q: got %0d expected 5", r_q); end
        n_checks++; if (r_busy1 !== 1'b1 || r_busy_after !== 1'b0) begin n_fail++; $display("FAIL goto_busy: got %b/%b expected 1/0", r_busy1, r_busy_after); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL goto_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_goto_zero;
        preload_q(3'd6);
        run_cmd(2'b00, 3'd6, 3'd0, 3'd0, 4'd0, 0, 0);
        n_checks++; if (r_steps !== 0) begin n_fail++; $display("FAIL goto0_steps: got %0d expected 0", r_steps); end
        n_checks++; if (r_done_edge !== 3) begin n_fail++; $display("FAIL goto0_done_edge: got %0d expected 3", r_done_edge); end
        n_checks++; if (r_err !== 2'b00) begin n_fail++; $display("FAIL goto0_err: got %b expected 00", r_err); end
    endtask

    task automatic test_sweep;
        preload_q(3'd2);
        run_cmd(2'b01, 3'd0, 3'd2, 3'd5, 4'd2, 0, 0);
        n_checks++; if (r_steps !== 6) begin n_fail++; $display("FAIL sweep_steps: got %0d expected 6", r_steps); end
        n_checks++; if (r_ud_bits[5:0] !== 6'b000111) begin n_fail++; $display("FAIL sweep_ud: got %b expected 000111", r_ud_bits[5:0]); end
        n_checks++; if (r_first !== 2 || r_last !== 7) begin n_fail++; $display("FAIL sweep_step_edges: got %0d..%0d expected 2..7", r_first, r_last); end
        n_checks++; if (r_done_edge !== 9) begin n_fail++; $display("FAIL sweep_done_edge: got %0d expected 9", r_done_edge); end
        n_checks++; if (r_q !== 3'd2 || r_err !== 2'b00) begin n_fail++; $display("FAIL sweep_result: got q=%0d err=%b expected q=2 err=00", r_q, r_err); end
    endtask

    task automatic test_sweep_edges;
        // Starting at hi: first leg goes down, one leg ends at lo.
        preload_q(3'd3);
        run_cmd(2'b01, 3'd0, 3'd1, 3'd3, 4'd1, 0, 0);
        n_checks++; if (r_steps !== 2 || r_ud_bits[1:0] !== 2'b00) begin n_fail++; $display("FAIL sweep_hi_steps: got %0d ud=%b expected 2 ud=00", r_steps, r_ud_bits[1:0]); end
        n_checks++; if (r_done_edge !== 5 || r_q !== 3'd1 || r_err !== 2'b00) begin n_fail++; $display("FAIL sweep_hi_result: got edge=%0d q=%0d err=%b expected 5/1/00", r_done_edge, r_q, r_err); end
        // Zero turns: no steps at all.
        run_cmd(2'b01, 3'd0, 3'd1, 3'd3, 4'd0, 0, 0);
        n_checks++; if (r_steps !== 0 || r_done_edge !== 3 || r_err !== 2'b00) begin n_fail++; $display("FAIL sweep_zero_turns: got steps=%0d edge=%0d err=%b expected 0/3/00", r_steps, r_done_edge, r_err); end
    endtask

    task automatic test_bad_args;
        preload_q(3'd4);
        run_cmd(2'b01, 3'd0, 3'd5, 3'd3, 4'd2, 0, 0);
        n_checks++; if (r_done_edge !== 1 || r_err !== 2'b01 || r_steps !== 0) begin n_fail++; $display("FAIL bad_lo_hi: got edge=%0d err=%b steps=%0d expected 1/01/0", r_done_edge, r_err, r_steps); end
        n_checks++; if (r_busy1 !== 1'b0) begin n_fail++; $display("FAIL bad_busy: got %b expected 0", r_busy1); end
        @(posedge clk); #1;
        n_checks++; if (err !== 2'b01 || done !== 1'b0) begin n_fail++; $display("FAIL bad_err_hold: got err=%b done=%b expected 01/0", err, done); end
        run_cmd(2'b10, 3'd6, 3'd0, 3'd0, 4'd0, 0, 0);
        n_checks++; if (r_done_edge !== 1 || r_err !== 2'b01 || r_steps !== 0) begin n_fail++; $display("FAIL bad_mode: got edge=%0d err=%b steps=%0d expected 1/01/0", r_done_edge, r_err, r_steps); end
        preload_q(3'd6);
        run_cmd(2'b01, 3'd0, 3'd2, 3'd4, 4'd1, 0, 0);
        n_checks++; if (r_done_edge !== 1 || r_err !== 2'b01 || r_steps !== 0) begin n_fail++; $display("FAIL bad_q_range: got edge=%0d err=%b steps=%0d expected 1/01/0", r_done_edge, r_err, r_steps); end
    endtask

    task automatic test_abort;
        preload_q(3'd0);
        run_cmd(2'b00, 3'd7, 3'd0, 3'd0, 4'd0, 4, 0);
        n_checks++; if (r_steps !== 2) begin n_fail++; $display("FAIL abort_steps: got %0d expected 2", r_steps); end
        n_checks++; if (r_done_edge !== 5 || r_err !== 2'b11) begin n_fail++; $display("FAIL abort_result: got edge=%0d err=%b expected 5/11", r_done_edge, r_err); end
        n_checks++; if (r_q !== 3'd2) begin n_fail++; $display("FAIL abort_q: got %0d expected 2", r_q); end
    endtask

    task automatic test_mismatch;
        preload_q(3'd0);
        drop_en = 1'b1;
        run_cmd(2'b00, 3'd3, 3'd0, 3'd0, 4'd0, 0, 0);
        drop_en = 1'b0;
        n_checks++; if (r_steps !== 3 || r_done_edge !== 6) begin n_fail++; $display("FAIL mismatch_timing: got steps=%0d edge=%0d expected 3/6", r_steps, r_done_edge); end
        n_checks++; if (r_err !== 2'b10 || r_q !== 3'd2) begin n_fail++; $display("FAIL mismatch_err: got err=%b q=%0d expected 10/2", r_err, r_q); end
    endtask

    task automatic test_back_to_back;
        preload_q(3'd2);
        // A second start with different args mid-run must be ignored.
        run_cmd(2'b00, 3'd6, 3'd0, 3'd0, 4'd0, 0, 3);
        n_checks++; if (r_err_start !== 2'b00) begin n_fail++; $display("FAIL b2b_err_clear: got %b expected 00", r_err_start); end
        n_checks++; if (r_steps !== 4 || r_done_edge !== 7) begin n_fail++; $display("FAIL b2b_first: got steps=%0d edge=%0d expected 4/7", r_steps, r_done_edge); end
        n_checks++; if (r_q !== 3'd6 || r_err !== 2'b00) begin n_fail++; $display("FAIL b2b_first_result: got q=%0d err=%b expected 6/00", r_q, r_err); end
        run_cmd(2'b00, 3'd4, 3'd0, 3'd0, 4'd0, 0, 0);
        n_checks++; if (r_steps !== 2 || r_ud_bits[1:0] !== 2'b00 || r_done_edge !== 5) begin n_fail++; $display("FAIL b2b_second: got steps=%0d ud=%b edge=%0d expected 2/00/5", r_steps, r_ud_bits[1:0], r_done_edge); end
        n_checks++; if (r_q !== 3'd4 || r_err !== 2'b00) begin n_fail++; $display("FAIL b2b_second_result: got q=%0d err=%b expected 4/00", r_q, r_err); end
    endtask

    task automatic test_reset_mid;
        logic saw_done;
        preload_q(3'd1);
        mode = 2'b01; lo = 3'd1; hi = 3'd6; turns = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cnt_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got cnt_en=%b busy=%b expected 1/1", cnt_en, busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (cnt_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got cnt_en=%b busy=%b done=%b expected 0/0/0", cnt_en, busy, done); end
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %b expected 0", saw_done); end
        preload_q(3'd3);
        run_cmd(2'b00, 3'd1, 3'd0, 3'd0, 4'd0, 0, 0);
        n_checks++; if (r_steps !== 2 || r_done_edge !== 5 || r_q !== 3'd1 || r_err !== 2'b00) begin n_fail++; $display("FAIL rstmid_after: got steps=%0d edge=%0d q=%0d err=%b expected 2/5/1/00", r_steps, r_done_edge, r_q, r_err); end
    endtask

    initial begin
        test_reset();
        test_goto_up();
        test_goto_zero();
        test_sweep();
        test_sweep_edges();
        test_bad_args();
        test_abort();
        test_mismatch();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
